// File: rtl/reg_seq_ctrl.sv
// reg_seq_ctrl: multi-cycle sequencer for the R1/R2/R3 register group.
// Accepts 8-bit instructions (and LDI immediates) over valid/ready.
// It drives the register-group read/write addresses, the active-low write enable,
// the ALU opcode and the write-data source select.
// Optional build macro: REG_SEQ_FLAGS_EN adds zero/carry flag capture for ADD/SUB/INC.
module reg_seq_ctrl #(
  parameter int unsigned DW = 8,
  parameter int unsigned AW = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          ins_valid,
  input  logic [DW-1:0] ins,
  output logic          ins_ready,
  output logic [AW-1:0] raa,
  output logic [AW-1:0] rwba,
  output logic          we,
  output logic [2:0]    alu_op,
  output logic          i_sel,
  output logic [DW-1:0] imm_out,
  output logic          busy,
  output logic          done,
`ifdef REG_SEQ_FLAGS_EN
  input  logic          alu_z,
  input  logic          alu_c,
  output logic          z_flag,
  output logic          c_flag,
`endif
  output logic          err
);

  localparam logic [3:0] OpNop = 4'd0;
  localparam logic [3:0] OpMov = 4'd1;
  localparam logic [3:0] OpAdd = 4'd2;
  localparam logic [3:0] OpSub = 4'd3;
  localparam logic [3:0] OpAnd = 4'd4;
  localparam logic [3:0] OpOr  = 4'd5;
  localparam logic [3:0] OpNot = 4'd6;
  localparam logic [3:0] OpInc = 4'd7;
  localparam logic [3:0] OpLdi = 4'd8;

  typedef enum logic [2:0] {
    StIdle,
    StDecode,
    StExec,
    StImm,
    StWrite
  } state_e;

  state_e          state_q, state_d;
  logic [3:0]      op_q, op_d;
  logic [1:0]      src_q, src_d;
  logic [1:0]      dst_q, dst_d;
  logic [AW-1:0]   raa_q, raa_d;
  logic [AW-1:0]   rwba_q, rwba_d;
  logic [2:0]      alu_op_q, alu_op_d;
  logic            i_sel_q, i_sel_d;
  logic [DW-1:0]   imm_q, imm_d;
  logic            we_q, we_d;
  logic [2:0]      alu_dec;
  logic            op_illegal;

  assign op_illegal = (op_q > OpLdi);

  // Map the latched opcode onto the ALU function code; non-ALU opcodes select PASS.
  always_comb begin
    alu_dec = 3'd0;
    case (op_q)
      OpMov:   alu_dec = 3'd0;
      OpAdd:   alu_dec = 3'd1;
      OpSub:   alu_dec = 3'd2;
      OpAnd:   alu_dec = 3'd3;
      OpOr:    alu_dec = 3'd4;
      OpNot:   alu_dec = 3'd5;
      OpInc:   alu_dec = 3'd6;
      default: alu_dec = 3'd0;
    endcase
  end

  // Next-state and registered-output logic; we only goes low on entry to WRITE.
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    src_d    = src_q;
    dst_d    = dst_q;
    raa_d    = raa_q;
    rwba_d   = rwba_q;
    alu_op_d = alu_op_q;
    i_sel_d  = i_sel_q;
    imm_d    = imm_q;
    we_d     = 1'b1;
    unique case (state_q)
      StIdle: begin
        if (ins_valid) begin
          op_d    = ins[7:4];
          src_d   = ins[3:2];
          dst_d   = ins[1:0];
          state_d = StDecode;
        end
      end
      StDecode: begin
        raa_d    = AW'(src_q);
        rwba_d   = AW'(dst_q);
        alu_op_d = alu_dec;
        if (op_q == OpNop || op_illegal) begin
          state_d = StIdle;
        end else if (op_q == OpLdi) begin
          state_d = StImm;
        end else begin
          state_d = StExec;
        end
      end
      StExec: begin
        // Register read and ALU have settled; commit the ALU result next cycle.
        i_sel_d = 1'b0;
        we_d    = 1'b0;
        state_d = StWrite;
      end
      StImm: begin
        if (ins_valid) begin
          imm_d   = ins;
          i_sel_d = 1'b1;
          we_d    = 1'b0;
          state_d = StWrite;
        end
      end
      StWrite: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and output registers; reset forces we high immediately, even mid-write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      op_q     <= OpNop;
      src_q    <= 2'b00;
      dst_q    <= 2'b00;
      raa_q    <= '0;
      rwba_q   <= '0;
      alu_op_q <= 3'd0;
      i_sel_q  <= 1'b0;
      imm_q    <= '0;
      we_q     <= 1'b1;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      src_q    <= src_d;
      dst_q    <= dst_d;
      raa_q    <= raa_d;
      rwba_q   <= rwba_d;
      alu_op_q <= alu_op_d;
      i_sel_q  <= i_sel_d;
      imm_q    <= imm_d;
      we_q     <= we_d;
    end
  end

  assign ins_ready = (state_q == StIdle) || (state_q == StImm);
  assign busy      = (state_q != StIdle);
  // NOP retires from DECODE; every writing instruction retires in WRITE.
  assign done      = (state_q == StWrite) || ((state_q == StDecode) && (op_q == OpNop));
  assign err       = (state_q == StDecode) && op_illegal;
  assign raa       = raa_q;
  assign rwba      = rwba_q;
  assign we        = we_q;
  assign alu_op    = alu_op_q;
  assign i_sel     = i_sel_q;
  assign imm_out   = imm_q;

`ifdef REG_SEQ_FLAGS_EN
  logic z_q, c_q;

  // Capture ALU flags while an arithmetic result is being committed; other ops hold them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      z_q <= 1'b0;
      c_q <= 1'b0;
    end else if (state_q == StWrite && (op_q == OpAdd || op_q == OpSub || op_q == OpInc)) begin
      z_q <= alu_z;
      c_q <= alu_c;
    end
  end

  assign z_flag = z_q;
  assign c_flag = c_q;
`endif

endmodule

// File: tb/tb_reg_seq_ctrl.sv
// Self-checking bench for reg_seq_ctrl: directed scenarios plus randomized instructions
// checked against a cycle-timeline model derived from the opcode class.
module tb_reg_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ins_valid;
  logic [7:0] ins;
  logic       ins_ready;
  logic [1:0] raa;
  logic [1:0] rwba;
  logic       we;
  logic [2:0] alu_op;
  logic       i_sel;
  logic [7:0] imm_out;
  logic       busy;
  logic       done;
  logic       err;
`ifdef REG_SEQ_FLAGS_EN
  logic       alu_z;
  logic       alu_c;
  logic       z_flag;
  logic       c_flag;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  reg_seq_ctrl #(
    .DW(8),
    .AW(2)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .ins_valid(ins_valid),
    .ins      (ins),
    .ins_ready(ins_ready),
    .raa      (raa),
    .rwba     (rwba),
    .we       (we),
    .alu_op   (alu_op),
    .i_sel    (i_sel),
    .imm_out  (imm_out),
    .busy     (busy),
    .done     (done),
`ifdef REG_SEQ_FLAGS_EN
    .alu_z    (alu_z),
    .alu_c    (alu_c),
    .z_flag   (z_flag),
    .c_flag   (c_flag),
`endif
    .err      (err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Cycle (after the accept edge) in which the write happens; 0 = instruction never writes.
  function automatic int write_cycle(input logic [3:0] op, input int d);
    if (op == 4'd0 || op > 4'd8) return 0;
    if (op == 4'd8) return 3 + d;
    return 3;
  endfunction

  // MOV..INC are opcodes 1..7 and map onto ALU functions PASS..INC in listed order.
  function automatic logic [2:0] exp_alu(input logic [3:0] op);
    return 3'(op - 4'd1);
  endfunction

  // Issue one instruction from IDLE and check every cycle until the controller is idle again.
  task automatic run_ins(input string name, input logic [7:0] b, input int d,
                         input logic [7:0] imm);
    logic [3:0] op;
    logic [4:0] got;
    logic [4:0] exp;
    int         wr;
    int         last;
    bit         nop;
    bit         ill;
    bit         ldi;
    op   = b[7:4];
    nop  = (op == 4'd0);
    ill  = (op > 4'd8);
    ldi  = (op == 4'd8);
    wr   = write_cycle(op, d);
    last = (wr != 0) ? wr + 1 : 2;
    checks++;
    if (ins_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL %s idle: ready=%b busy=%b, required ready=1 busy=0", name, ins_ready, busy);
    end
    ins       = b;
    ins_valid = 1'b1;
    tick();
    for (int c = 1; c <= last; c++) begin
      exp = {c < last, c != wr, (c == wr) || (nop && c == 1), ill && c == 1,
             (c == last) || (ldi && c >= 2 && c < wr)};
      got = {busy, we, done, err, ins_ready};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL %s c%0d {busy,we,done,err,ready}: got %b required %b", name, c, got, exp);
      end
      if (wr != 0 && c >= 2 && c <= wr) begin
        checks++;
        if ({raa, rwba} !== {b[3:2], b[1:0]}) begin
          errors++;
          $display("FAIL %s c%0d raa/rwba: got %b/%b required %b/%b", name, c, raa, rwba,
                   b[3:2], b[1:0]);
        end
      end
      if (c == wr) begin
        checks++;
        if (i_sel !== ldi) begin
          errors++;
          $display("FAIL %s i_sel: got %b required %b", name, i_sel, ldi);
        end
        checks++;
        if (ldi) begin
          if (imm_out !== imm) begin
            errors++;
            $display("FAIL %s imm_out: got %h required %h", name, imm_out, imm);
          end
        end else if (alu_op !== exp_alu(op)) begin
          errors++;
          $display("FAIL %s alu_op: got %0d required %0d", name, alu_op, exp_alu(op));
        end
      end
      // Outside IDLE/IMM the source may present junk; inside IMM only the immediate beat.
      if (c == last) begin
        ins_valid = 1'b0;
      end else if (ldi && c == wr - 1) begin
        ins_valid = 1'b1;
        ins       = imm;
      end else if (ldi && c >= 2) begin
        ins_valid = 1'b0;
      end else begin
        ins_valid = 1'b1;
        ins       = 8'($urandom);
      end
      if (c < last) tick();
    end
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    ins_valid = 1'b0;
    ins       = 8'h00;
`ifdef REG_SEQ_FLAGS_EN
    alu_z = 1'b0;
    alu_c = 1'b0;
`endif
    #12;
    checks++;
    if ({raa, rwba, we, alu_op, i_sel, imm_out, busy, done, err, ins_ready} !==
        {2'b00, 2'b00, 1'b1, 3'd0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL reset: raa=%b rwba=%b we=%b alu_op=%0d i_sel=%b imm=%h busy=%b done=%b err=%b",
               raa, rwba, we, alu_op, i_sel, imm_out, busy, done, err);
    end
`ifdef REG_SEQ_FLAGS_EN
    checks++;
    if ({z_flag, c_flag} !== 2'b00) begin
      errors++;
      $display("FAIL reset flags: got %b%b required 00", z_flag, c_flag);
    end
`endif
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_directed();
    run_ins("add_27", 8'h27, 0, 8'h00);
    run_ins("ldi_80", 8'h80, 5, 8'h5A);
    run_ins("ill_f3", 8'hF3, 0, 8'h00);
    run_ins("mov_same", 8'h15, 0, 8'h00);
    run_ins("nop_05", 8'h05, 0, 8'h00);
    run_ins("ldi_now", 8'h8E, 0, 8'hC3);
  endtask

  task automatic test_reset_mid_write();
    ins       = 8'h27;
    ins_valid = 1'b1;
    tick();
    ins_valid = 1'b0;
    tick();
    tick();
    checks++;
    if (we !== 1'b0) begin
      errors++;
      $display("FAIL rst_write pre: we=%b required 0", we);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({we, busy, done, ins_ready} !== 4'b1001) begin
      errors++;
      $display("FAIL rst_write async {we,busy,done,ready}: got %b required 1001",
               {we, busy, done, ins_ready});
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    run_ins("nop_after_rst", 8'h05, 0, 8'h00);
  endtask

  task automatic test_back_to_back();
    int second  = -1;
    int low_run = 0;
    int max_low = 0;
    int dones   = 0;
    ins       = 8'h27;
    ins_valid = 1'b1;
    tick();
    ins = 8'h2E;
    for (int c = 1; c <= 10; c++) begin
      if (we === 1'b0) begin
        low_run++;
        if (low_run > max_low) max_low = low_run;
      end else begin
        low_run = 0;
      end
      if (done === 1'b1) dones++;
      if (c == 7) begin
        checks++;
        if ({we, raa, rwba} !== {1'b0, 2'b11, 2'b10}) begin
          errors++;
          $display("FAIL b2b second write {we,raa,rwba}: got %b required 01110", {we, raa, rwba});
        end
      end
      if (ins_valid && ins_ready && second < 0) second = c;
      tick();
      if (second > 0) ins_valid = 1'b0;
    end
    checks++;
    if (second != 4) begin
      errors++;
      $display("FAIL b2b accept spacing: got %0d required 4", second);
    end
    checks++;
    if (max_low != 1) begin
      errors++;
      $display("FAIL b2b we low run: got %0d required 1", max_low);
    end
    checks++;
    if (dones != 2) begin
      errors++;
      $display("FAIL b2b done pulses: got %0d required 2", dones);
    end
  endtask

  task automatic test_random();
    logic [7:0] b;
    logic [7:0] imm;
    int         d;
    for (int i = 0; i < 40; i++) begin
      b   = 8'($urandom);
      imm = 8'($urandom);
      d   = $urandom_range(0, 3);
      run_ins("rand", b, d, imm);
      if ($urandom_range(0, 3) == 0) tick();
    end
  endtask

`ifdef REG_SEQ_FLAGS_EN
  task automatic test_flags();
    alu_z = 1'b0;
    alu_c = 1'b1;
    run_ins("flg_add", 8'h24, 0, 8'h00);
    checks++;
    if ({z_flag, c_flag} !== 2'b01) begin
      errors++;
      $display("FAIL flags add: got %b%b required 01", z_flag, c_flag);
    end
    alu_z = 1'b1;
    alu_c = 1'b0;
    run_ins("flg_sub", 8'h36, 0, 8'h00);
    checks++;
    if ({z_flag, c_flag} !== 2'b10) begin
      errors++;
      $display("FAIL flags sub: got %b%b required 10", z_flag, c_flag);
    end
    alu_z = 1'b0;
    alu_c = 1'b1;
    run_ins("flg_mov", 8'h11, 0, 8'h00);
    checks++;
    if ({z_flag, c_flag} !== 2'b10) begin
      errors++;
      $display("FAIL flags mov hold: got %b%b required 10", z_flag, c_flag);
    end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_directed();
    test_reset_mid_write();
    test_back_to_back();
    test_random();
`ifdef REG_SEQ_FLAGS_EN
    test_flags();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
